// File: rtl/popcount_scheduler.sv
// Round-robin scheduler sharing one external 32-bit popcount tree among NUM_REQ requesters,
// accumulating WINDOW beats per result. Define POPCOUNT_SCHEDULER_SATURATE_EN for saturating sums.
module popcount_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int WINDOW    = 8,
  parameter int TREE_LAT  = 1,
  parameter int ACC_WIDTH = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][31:0]   req_bits,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [31:0]                tree_inputs,
  input  logic [5:0]                 tree_sum,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic [ACC_WIDTH-1:0]       out_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1) + 1;

  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [5:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {{(ACC_WIDTH - 5){1'b0}}, b};
`ifdef POPCOUNT_SCHEDULER_SATURATE_EN
    return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
`else
    return s[ACC_WIDTH-1:0];
`endif
  endfunction

  logic [WW-1:0]        beat_q [NUM_REQ];
  logic [WW-1:0]        beat_d [NUM_REQ];
  logic [ACC_WIDTH-1:0] acc_q  [NUM_REQ];
  logic [ACC_WIDTH-1:0] acc_d  [NUM_REQ];
  logic [IW-1:0]        last_q, last_d;
  logic [CW-1:0]        resv_q, resv_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [IW-1:0]        mem_id_q  [OUT_DEPTH];
  logic [ACC_WIDTH-1:0] mem_cnt_q [OUT_DEPTH];

  logic [NUM_REQ-1:0]   fin_next_s, elig_s;
  logic                 credit_ok_s, pop_s, push_s;
  logic                 gnt_any_s, gnt_fin_s;
  logic [IW-1:0]        gnt_id_s;
  logic                 ret_v_s, ret_fin_s;
  logic [IW-1:0]        ret_id_s;
  logic [ACC_WIDTH-1:0] sum_s;

  // resv_q counts FIFO entries plus final beats still inside the tree
  assign pop_s       = out_valid && out_ready;
  assign credit_ok_s = (resv_q - CW'(pop_s)) < CW'(OUT_DEPTH);

  always_comb begin
    fin_next_s = '0;
    elig_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fin_next_s[i] = (beat_q[i] == WW'(WINDOW - 1));
      elig_s[i]     = req_valid[i] && !RST && (!fin_next_s[i] || credit_ok_s);
    end
  end

  always_comb begin : arb
    int   idx;
    logic hit;
    idx       = 0;
    hit       = 1'b0;
    gnt_any_s = 1'b0;
    gnt_id_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx       = int'(last_q) + 1 + k;
      idx       = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
      hit       = elig_s[idx] && !gnt_any_s;
      gnt_id_s  = hit ? IW'(idx) : gnt_id_s;
      gnt_any_s = gnt_any_s | hit;
    end
  end

  assign gnt_fin_s   = gnt_any_s && fin_next_s[gnt_id_s];
  assign req_ready   = gnt_any_s ? (NUM_REQ'(1) << gnt_id_s) : '0;
  assign tree_inputs = gnt_any_s ? req_bits[gnt_id_s] : 32'h0;

  generate
    if (TREE_LAT == 0) begin : g_nolat
      assign ret_v_s   = gnt_any_s;
      assign ret_id_s  = gnt_id_s;
      assign ret_fin_s = gnt_fin_s;
    end else begin : g_lat
      logic [TREE_LAT-1:0] tv_q, tf_q;
      logic [IW-1:0]       tid_q [TREE_LAT];

      always_ff @(posedge CLK) begin
        if (RST) begin
          tv_q <= '0;
          tf_q <= '0;
          for (int s = 0; s < TREE_LAT; s++) tid_q[s] <= '0;
        end else begin
          tv_q[0]  <= gnt_any_s;
          tf_q[0]  <= gnt_fin_s;
          tid_q[0] <= gnt_id_s;
          for (int s = 1; s < TREE_LAT; s++) begin
            tv_q[s]  <= tv_q[s-1];
            tf_q[s]  <= tf_q[s-1];
            tid_q[s] <= tid_q[s-1];
          end
        end
      end

      assign ret_v_s   = tv_q[TREE_LAT-1];
      assign ret_fin_s = tf_q[TREE_LAT-1];
      assign ret_id_s  = tid_q[TREE_LAT-1];
    end
  endgenerate

  assign sum_s  = acc_add(acc_q[ret_id_s], tree_sum);
  assign push_s = ret_v_s && ret_fin_s;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_d[i] = (gnt_any_s && gnt_id_s == IW'(i)) ?
                  (fin_next_s[i] ? '0 : beat_q[i] + WW'(1)) : beat_q[i];
      acc_d[i]  = (ret_v_s && ret_id_s == IW'(i)) ?
                  (ret_fin_s ? '0 : sum_s) : acc_q[i];
    end
    last_d = gnt_any_s ? gnt_id_s : last_q;
    resv_d = resv_q + CW'(gnt_fin_s) - CW'(pop_s);
    cnt_d  = cnt_q + CW'(push_s) - CW'(pop_s);
    wr_d   = push_s ? ((wr_q == PW'(OUT_DEPTH - 1)) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d   = pop_s  ? ((rd_q == PW'(OUT_DEPTH - 1)) ? '0 : rd_q + PW'(1)) : rd_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= IW'(NUM_REQ - 1);
      resv_q <= '0;
      cnt_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        beat_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      last_q <= last_d;
      resv_q <= resv_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        beat_q[i] <= beat_d[i];
        acc_q[i]  <= acc_d[i];
      end
    end
  end

  // Storage is not reset; the empty flag masks stale contents on the outputs
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_id_q[wr_q]  <= ret_id_s;
      mem_cnt_q[wr_q] <= sum_s;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_id    = out_valid ? mem_id_q[rd_q]  : '0;
  assign out_count = out_valid ? mem_cnt_q[rd_q] : '0;

endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed + random bench for popcount_scheduler with a latency-accurate tree model
// and an in-order result scoreboard fed from observed grants.
module tb_popcount_scheduler;

  localparam int NR  = 4;
  localparam int WIN = 8;
  localparam int LAT = 2;
  localparam int AW  = 16;
  localparam int OD  = 4;

  logic              CLK;
  logic              RST;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0][31:0] req_bits;
  logic [NR-1:0]     req_ready;
  logic [31:0]       tree_inputs;
  logic [5:0]        tree_sum;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_id;
  logic [AW-1:0]     out_count;

  popcount_scheduler #(.NUM_REQ(NR), .WINDOW(WIN), .TREE_LAT(LAT),
                       .ACC_WIDTH(AW), .OUT_DEPTH(OD)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_bits(req_bits),
    .req_ready(req_ready), .tree_inputs(tree_inputs), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_count(out_count));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [5:0] pc(input logic [31:0] x);
    return 6'($countones(x));
  endfunction

  // External adder tree: popcount of tree_inputs, LAT cycles later
  logic [5:0] tpipe [LAT];
  always @(posedge CLK) begin
    tpipe[0] <= pc(tree_inputs);
    for (int s = 1; s < LAT; s++) tpipe[s] <= tpipe[s-1];
  end
  assign tree_sum = tpipe[LAT-1];

  typedef struct { logic [1:0] id; logic [AW-1:0] cnt; } res_t;
  res_t          exp_q[$];
  logic [AW-1:0] m_sum  [NR];
  int            m_beat [NR];
  int            gnt_cnt;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      m_sum[i]  = '0;
      m_beat[i] = 0;
    end
  endtask

  // Once per cycle, after inputs settle: score pops, check grant rules, record grants
  task automatic settle();
    res_t e;
    #1;
    if (!RST) begin
      if (out_valid && out_ready) begin
        chk("pop_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("res_id", 64'(out_id), 64'(e.id));
          chk("res_count", 64'(out_count), 64'(e.cnt));
        end
      end
      chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      chk("ready_subset", 64'(req_ready & ~req_valid), 64'd0);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          gnt_cnt++;
          m_sum[i] = m_sum[i] + AW'(pc(req_bits[i]));
          if (m_beat[i] == WIN - 1) begin
            e.id  = 2'(i);
            e.cnt = m_sum[i];
            exp_q.push_back(e);
            m_sum[i]  = '0;
            m_beat[i] = 0;
          end else begin
            m_beat[i]++;
          end
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic cyc();
    settle();
    adv();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_ready_zero", 64'(req_ready), 64'd0);
    chk("rst_tree_zero", 64'(tree_inputs), 64'd0);
    adv();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_id", 64'(out_id), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    RST = 1'b0;
    clear_model();
  endtask

  initial begin
    int n;
    total = 0; bad = 0; gnt_cnt = 0;
    RST = 1'b1; req_valid = '0; req_bits = '0; out_ready = 1'b0;
    clear_model();
    @(negedge CLK);
    adv();
    do_reset();

    // Round-robin with all requesters streaming all-ones beats
    for (int i = 0; i < NR; i++) req_bits[i] = 32'hFFFF_FFFF;
    req_valid = 4'hF; out_ready = 1'b1;
    for (int k = 0; k < 36; k++) begin
      settle();
      chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      adv();
    end
    req_valid = '0;
    for (int k = 0; k < 8; k++) cyc();
    chk("rr_drained", 64'(exp_q.size()), 64'd0);
    chk("rr_empty", 64'(out_valid), 64'd0);

    // Single requester, fixed latency to the result
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0100; req_bits[2] = 32'h0000_000F;
    for (int b = 0; b < WIN; b++) begin
      settle();
      chk("solo_grant", 64'(req_ready), 64'd4);
      adv();
    end
    req_valid = '0;
    settle(); chk("solo_lat0", 64'(out_valid), 64'd0); adv();
    settle(); chk("solo_lat1", 64'(out_valid), 64'd0); adv();
    out_ready = 1'b1;
    settle();
    chk("solo_lat2", 64'(out_valid), 64'd1);
    chk("solo_id", 64'(out_id), 64'd2);
    chk("solo_count", 64'(out_count), 64'd32);
    adv();
    settle(); chk("solo_popped", 64'(out_valid), 64'd0); adv();

    // FIFO back-pressure: final beats stall, non-final beats continue
    do_reset();
    gnt_cnt = 0; out_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < NR; i++) req_bits[i] = $urandom;
      cyc();
    end
    chk("stall_grants", 64'(gnt_cnt), 64'd60);
    chk("stall_queued", 64'(exp_q.size()), 64'(OD));
    chk("stall_full_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) cyc();
    req_valid = '0;
    for (int k = 0; k < 10; k++) cyc();
    chk("stall_drained", 64'(exp_q.size()), 64'd0);
    chk("stall_empty", 64'(out_valid), 64'd0);

    // Reset mid-window with a queued result discards everything
    do_reset();
    out_ready = 1'b0; req_valid = 4'b0010; req_bits[1] = 32'hFFFF_FFFF;
    for (int k = 0; k < WIN + 5; k++) cyc();
    req_valid = '0;
    for (int k = 0; k < 3; k++) cyc();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_id", 64'(out_id), 64'd1);
    req_valid = 4'b0010;
    do_reset();
    for (int k = 0; k < WIN; k++) cyc();
    req_valid = '0;
    for (int k = 0; k < 3; k++) cyc();
    chk("post_rst_count", 64'(out_count), 64'd256);
    chk("post_rst_id", 64'(out_id), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

    // Random valid/ready traffic
    do_reset();
    gnt_cnt = 0; n = 0;
    while (gnt_cnt < 10000 && n < 40000) begin
      req_valid = 4'($urandom);
      for (int i = 0; i < NR; i++) req_bits[i] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    chk("rand_budget", 64'(gnt_cnt >= 10000), 64'd1);
    req_valid = '0; out_ready = 1'b1; n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cyc();
      n++;
    end
    for (int k = 0; k < 4; k++) cyc();
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    chk("rand_empty", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/popcount_scheduler.md
POPCOUNT_SCHEDULER -- requirements
Module: popcount_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one 32-input adder tree (2..8).
REQ-002 Parameter WINDOW, default 8: 32-bit beats accumulated per result (1..256).
REQ-003 Parameter TREE_LAT, default 1: cycles from tree_inputs driven to tree_sum valid (0..4).
REQ-004 Parameter ACC_WIDTH, default 16: accumulator/result width (>=6).
REQ-005 Parameter OUT_DEPTH, default 4: result FIFO entries (>=1).
REQ-006 CLK  in  1  rising-edge clock; the only clock.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  NUM_REQ  requester i offers a beat.
REQ-009 req_bits  in  NUM_REQ x 32  beat data per requester.
REQ-010 req_ready  out  NUM_REQ  one-hot grant; beat i transfers when req_valid[i] && req_ready[i].
REQ-011 tree_inputs  out  32  bits driven to the shared tree.
REQ-012 tree_sum  in  6  tree result (0..32), TREE_LAT cycles after tree_inputs.
REQ-013 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-014 out_id  out  clog2(NUM_REQ)  requester owning the result.
REQ-015 out_count  out  ACC_WIDTH  popcount over WINDOW beats.

Function
REQ-016 At most one req_ready bit high per cycle; req_ready[i] never high when req_valid[i] is low.
REQ-017 Arbitration round-robin: search starts one past the last granted index, wrapping NUM_REQ-1 to 0; after reset the search starts at 0.
REQ-018 tree_inputs equals req_bits of the granted requester in the grant cycle, else 32'h0.
REQ-019 A tag pipeline of TREE_LAT stages carries (valid, id, final) with each grant; at TREE_LAT=0 the tag is used in the grant cycle.
REQ-020 Per-requester beat counter increments on each grant and wraps WINDOW-1 -> 0; a grant with counter == WINDOW-1 is a final beat.
REQ-021 On tag return, acc[id] += tree_sum; on a final-beat return, acc[id]+tree_sum is pushed to the result FIFO and acc[id] clears to 0 in the same cycle.
REQ-022 Credit rule: a final beat is granted only if (free FIFO entries - in-flight final beats) > 0, counting a same-cycle pop as freeing an entry; non-final beats are never blocked by the FIFO.
REQ-023 A requester whose next beat is final and lacks credit is skipped by the arbiter; other requesters are still served.
REQ-024 Result FIFO: first-word fall-through, out_valid = not empty; pop on out_valid && out_ready; simultaneous push and pop when full is legal and keeps occupancy.
REQ-025 Results for one id emerge in window order; ids interleave in completion order.
REQ-026 Overflow: acc and FIFO entry width ACC_WIDTH; arithmetic per REQ-033.

Reset
REQ-027 On RST high at a clock edge: req_ready=0, tree_inputs=0, out_valid=0, out_id=0, out_count=0.
REQ-028 Reset clears all accumulators, beat counters, tag pipeline, FIFO pointers, credits and the round-robin pointer; in-flight beats are discarded.
REQ-029 Reset mid-window discards partial sums; first result after reset covers exactly WINDOW post-reset beats.
REQ-030 req_ready stays 0 during the reset cycle and goes high no earlier than the cycle after RST falls.

Configuration
REQ-031 Macro POPCOUNT_SCHEDULER_SATURATE_EN selects overflow behaviour.
REQ-032 Defined: accumulator addition saturates at 2^ACC_WIDTH-1.
REQ-033 Undefined: accumulator addition wraps modulo 2^ACC_WIDTH.

Verification
REQ-034 NUM_REQ=4, all valid, all bits 32'hFFFFFFFF, out_ready=1 -> grants 0,1,2,3,0...; each id reports out_count=256 (WINDOW=8).
REQ-035 Only req 2 valid, req_bits=32'h0000000F, TREE_LAT=2 -> one result id=2, count=32, out_valid 2 cycles after 8th grant (+FIFO fall-through cycle 0).
REQ-036 out_ready=0, all requesters streaming -> exactly OUT_DEPTH results queued, then final beats stall while non-final beats continue; releasing out_ready drains in order with no loss.
REQ-037 RST asserted after 5 beats of req 1 -> outputs zero next cycle; after release, 8 beats of 32'hFFFFFFFF give count=256, not 416.
REQ-038 ACC_WIDTH=8, all-ones beats -> 256 -> count=255 with SATURATE_EN, count=0 without.
REQ-039 Random valid/ready with 10k beats -> per-id sums match scoreboard, req_ready one-hot, no FIFO overflow.
